// File: rtl/dm_sweep.sv
// Single-port byte-writable memory with a debug read port and a hardware clear sweep.
// The sweep runs after reset and on every clr request; port A is locked out while it runs.
module dm_sweep #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 8,
    parameter int                DEPTH   = 256,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     dout,
    input  logic [ADDR_W-1:0]     readAddr,
    output logic [DATA_W-1:0]     readData,
    input  logic                  clr,
    output logic                  busy,
    output logic                  wr_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic {
        SWEEP,
        READY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               wr_ok;
    logic               drop;

    // Widened compare so DEPTH == 2**ADDR_W does not overflow the address width.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            SWEEP: begin
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr == PTR_W'(DEPTH - 1)) begin
                    state_nxt = READY;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            READY: begin
                if (clr) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SWEEP;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign busy  = (state == SWEEP);
    assign drop  = we && ((state == SWEEP) || !in_range(addr) || clr);
    assign wr_ok = we && (state == READY) && in_range(addr) && !clr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= SWEEP;
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            wr_drop <= drop;
        end
    end

    // Array contents are not reset; the sweep is what gives them a defined value.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == SWEEP) begin
                mem[ptr] <= CLR_VAL;
            end else if (wr_ok) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr[PTR_W-1:0]][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

    assign dout     = ((state == READY) && in_range(addr)) ? mem[addr[PTR_W-1:0]] : '0;
    assign readData = in_range(readAddr) ? mem[readAddr[PTR_W-1:0]] : '0;

endmodule

// File: tb/tb_dm_sweep.sv
// Directed bench for dm_sweep: a default-size instance plus a DEPTH=128 instance for range checks.
module tb_dm_sweep;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr, readAddr, addr2, readAddr2;
    logic [15:0] din, din2;
    logic        we, we2, clr, clr2;
    logic [1:0]  be, be2;
    logic [15:0] dout, readData, dout2, readData2;
    logic        busy, wr_drop, busy2, wr_drop2;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    dm_sweep dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .be(be),
        .dout(dout), .readAddr(readAddr), .readData(readData), .clr(clr),
        .busy(busy), .wr_drop(wr_drop)
    );

    dm_sweep #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .CLR_VAL(16'h0000)) dut128 (
        .clk(clk), .reset(reset), .addr(addr2), .din(din2), .we(we2), .be(be2),
        .dout(dout2), .readAddr(readAddr2), .readData(readData2), .clr(clr2),
        .busy(busy2), .wr_drop(wr_drop2)
    );

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic        w;
        logic [1:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic write_a(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        addr = a; din = d; be = b; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    initial begin
        int n, m, bad;
        reset = 1'b0; addr = '0; din = '0; we = 1'b0; be = '0; readAddr = '0; clr = 1'b0;
        addr2 = '0; din2 = '0; we2 = 1'b0; be2 = '0; readAddr2 = '0; clr2 = 1'b0;

        tbl[0] = '{8'd3, 16'hc369, 1'b1, 2'b11, 16'hc369};
        tbl[1] = '{8'd3, 16'hffff, 1'b1, 2'b01, 16'hc3ff};
        tbl[2] = '{8'd3, 16'h0000, 1'b1, 2'b00, 16'hc3ff};
        tbl[3] = '{8'd3, 16'h1200, 1'b1, 2'b10, 16'h12ff};
        tbl[4] = '{8'd4, 16'ha5a5, 1'b1, 2'b11, 16'ha5a5};
        tbl[5] = '{8'd3, 16'h0000, 1'b0, 2'b11, 16'h12ff};
        tbl[6] = '{8'd4, 16'h0f0f, 1'b1, 2'b01, 16'ha50f};

        // reset held two edges
        step();
        step();
        chk("reset_busy", busy, 1);
        chk("reset_busy128", busy2, 1);
        chk("reset_dout", dout, 0);
        chk("reset_wr_drop", wr_drop, 0);

        reset = 1'b1;
        count_busy(n);
        chk("init_sweep_len", n, 256);
        chk("ready_busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            readAddr = 8'(i);
            #1;
            if (readData !== 16'h0000) bad++;
        end
        chk("init_sweep_zero", bad, 0);

        // byte-lane write table
        for (int i = 0; i < 7; i++) begin
            addr = tbl[i].a; din = tbl[i].d; be = tbl[i].b; we = tbl[i].w;
            step();
            we = 1'b0;
            #1;
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp);
            chk($sformatf("tbl%0d_drop", i), wr_drop, 0);
        end

        // same-cycle read/write on address 7
        write_a(8'd7, 16'h1234, 2'b11);
        readAddr = 8'd7; addr = 8'd7; din = 16'h0001; be = 2'b11; we = 1'b1;
        #1;
        chk("rw_old_readData", readData, 16'h1234);
        chk("rw_old_dout", dout, 16'h1234);
        step();
        we = 1'b0;
        #1;
        chk("rw_new_readData", readData, 16'h0001);

        // out-of-range write on the DEPTH=128 instance
        chk("d128_ready", busy2, 0);
        addr2 = 8'd72; din2 = 16'h5a5a; be2 = 2'b11; we2 = 1'b1;
        step();
        addr2 = 8'd200; din2 = 16'hffff; we2 = 1'b1;
        step();
        we2 = 1'b0;
        #1;
        chk("d128_drop_pulse", wr_drop2, 1);
        chk("d128_dout_oob", dout2, 0);
        step();
        chk("d128_drop_end", wr_drop2, 0);
        readAddr2 = 8'd72;
        #1;
        chk("d128_mem72", readData2, 16'h5a5a);
        readAddr2 = 8'd200;
        #1;
        chk("d128_rd_oob", readData2, 0);

        // double clr pulse: 100 cycles, restart, full sweep
        write_a(8'd5, 16'h0041, 2'b11);
        readAddr = 8'd5;
        #1;
        chk("fill5", readData, 16'h0041);
        clr = 1'b1;
        step();
        clr = 1'b0;
        n = 0;
        for (int k = 0; k < 99; k++) begin
            if (busy) n++;
            step();
        end
        if (busy) n++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        addr = 8'd3;
        #1;
        chk("sweep_dout_zero", dout, 0);
        count_busy(m);
        chk("clr_total_busy", n + m, 356);
        chk("clr_addr5", readData, 16'h0000);
        readAddr = 8'd3;
        #1;
        chk("clr_addr3", readData, 16'h0000);

        // dropped write during sweep, then reset at sweep cycle 50
        clr = 1'b1;
        step();
        clr = 1'b0;
        addr = 8'd3; din = 16'hffff; be = 2'b11; we = 1'b1;
        step();
        we = 1'b0;
        #1;
        chk("sweep_drop_pulse", wr_drop, 1);
        step();
        chk("sweep_drop_end", wr_drop, 0);
        for (int k = 0; k < 48; k++) step();
        reset = 1'b0;
        step();
        chk("midreset_busy", busy, 1);
        chk("midreset_dout", dout, 0);
        reset = 1'b1;
        count_busy(n);
        chk("midreset_sweep_len", n, 256);
        chk("midreset_addr3", readData, 16'h0000);

        // clr in READY discards a simultaneous write
        write_a(8'd9, 16'h7777, 2'b11);
        addr = 8'd9; din = 16'hbeef; be = 2'b11; we = 1'b1; clr = 1'b1;
        step();
        we = 1'b0; clr = 1'b0;
        #1;
        chk("clr_we_drop", wr_drop, 1);
        count_busy(n);
        readAddr = 8'd9;
        #1;
        chk("clr_we_addr9", readData, 16'h0000);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
